// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core: full-duplex UART. TX and RX share one oversampling tick.
//
// Parameters
//   CLK_HZ, BAUD, OVERSAMPLE (8 or 16), DATA_BITS (5..9),
//   PARITY (0 none, 1 even, 2 odd), STOP_BITS (1 or 2, TX only)
//
// Ports
//   clk            rising-edge clock
//   n_reset        synchronous, active-low reset
//   tx_data/valid  word to send, accepted when tx_valid && tx_ready
//   tx_ready       high only while the transmitter is idle
//   tx_pin         serial output, idles high
//   rx_pin         asynchronous serial input
//   rx_data        last received word
//   rx_valid       rx_data holds a word not yet taken (rx_ready)
//   rx_ready       consumer takes rx_data while rx_valid is high
//   rx_parity_err  parity mismatch on the word in rx_data
//   rx_frame_err   stop bit sampled low on the word in rx_data
//   rx_overrun     a frame was dropped because rx_data was still unread
// ---------------------------------------------------------------------------
module uart_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_pin,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV   = (CLK_HZ / (BAUD * OVERSAMPLE) < 1) ? 1 : CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BI_W  = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] S_LO     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] S_MID    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] S_HI     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // ---------------- shared oversampling tick ----------------
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!n_reset)  div_cnt_q <= '0;
    else if (tick) div_cnt_q <= '0;
    else           div_cnt_q <= div_cnt_q + DIV_W'(1);
  end

  // ---------------- transmitter ----------------
  tx_state_e               tx_state_q;
  logic [OS_W-1:0]         tx_cnt_q;
  logic [BI_W-1:0]         tx_bit_q;
  logic                    tx_stop_q;
  logic [DATA_BITS-1:0]    tx_shift_q;
  logic                    tx_par_q;
  logic                    tx_pin_q;
  logic                    tx_ready_q;
  logic                    tx_bit_end;

  assign tx_bit_end = tick && (tx_cnt_q == OS_LAST);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pin_q   <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      if (tx_state_q != TX_IDLE && tick)
        tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + OS_W'(1);
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            // Word and its parity are frozen here; tx_data may change freely.
            tx_shift_q <= tx_data;
            tx_par_q   <= (^tx_data) ^ PAR_ODD;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_pin_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_pin_q   <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_pin_q   <= tx_par_q;
                tx_state_q <= TX_PARITY;
              end else begin
                tx_pin_q   <= 1'b1;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + BI_W'(1);
              tx_pin_q   <= tx_shift_q[1];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_pin_q   <= 1'b1;
            tx_state_q <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop_q == STOP_LAST) begin
              tx_ready_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_stop_q <= 1'b1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_pin   = tx_pin_q;
  assign tx_ready = tx_ready_q;

  // ---------------- receiver ----------------
  // NOTE: rx_pin is asynchronous, so nothing reads it except this 2-flop
  // synchroniser; it resets to idle-high so reset never looks like a start bit.
  logic [1:0] rx_sync_q;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (!n_reset) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], rx_pin};
  end
  assign rx_s = rx_sync_q[1];

  rx_state_e               rx_state_q;
  logic [OS_W-1:0]         rx_cnt_q;
  logic [1:0]              rx_ones_q;   // high votes among the first two samples
  logic [BI_W-1:0]         rx_bit_q;
  logic [DATA_BITS-1:0]    rx_shift_q;
  logic                    rx_par_q;
  logic [DATA_BITS-1:0]    rx_data_q;
  logic                    rx_valid_q;
  logic                    rx_perr_q;
  logic                    rx_ferr_q;
  logic                    rx_ovr_q;
  logic                    rx_maj;
  logic                    rx_sample_hi;
  logic                    rx_bit_end;
  logic                    rx_done;
  logic                    rx_take;

  // Majority of three: the third sample is the live one at S_HI.
  assign rx_maj       = rx_ones_q[1] | (rx_ones_q[0] & rx_s);
  assign rx_sample_hi = tick && (rx_cnt_q == S_HI);
  assign rx_bit_end   = tick && (rx_cnt_q == OS_LAST);
  assign rx_done      = (rx_state_q == RX_STOP) && rx_sample_hi;
  assign rx_take      = rx_valid_q && rx_ready;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_ones_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (rx_state_q != RX_IDLE && tick) begin
        rx_cnt_q <= rx_bit_end ? '0 : rx_cnt_q + OS_W'(1);
        if (rx_bit_end)
          rx_ones_q <= '0;
        else if ((rx_cnt_q == S_LO || rx_cnt_q == S_MID) && rx_s)
          rx_ones_q <= rx_ones_q + 2'(1);
      end

      case (rx_state_q)
        RX_IDLE: begin
          // The detecting tick counts as tick 0 of the start bit.
          if (tick && !rx_s) begin
            rx_cnt_q   <= OS_W'(1);
            rx_ones_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_sample_hi && rx_maj) rx_state_q <= RX_IDLE;  // glitch
          else if (rx_bit_end)        rx_state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (rx_sample_hi) rx_shift_q <= {rx_maj, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_end) begin
            if (rx_bit_q == BIT_LAST) rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            else                      rx_bit_q   <= rx_bit_q + BI_W'(1);
          end
        end
        RX_PARITY: begin
          if (rx_sample_hi) rx_par_q   <= rx_maj;
          if (rx_bit_end)   rx_state_q <= RX_STOP;
        end
        RX_STOP: begin
          // Leave right after the stop-bit vote so a following start edge is seen.
          if (rx_sample_hi) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase

      // A frame finishing on the same cycle the old word is taken still lands.
      if (rx_done && (!rx_valid_q || rx_take)) begin
        rx_data_q  <= rx_shift_q;
        rx_perr_q  <= (PARITY != 0) && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
        rx_ferr_q  <= !rx_maj;
        rx_valid_q <= 1'b1;
        rx_ovr_q   <= 1'b0;
      end else if (rx_done) begin
        rx_ovr_q <= 1'b1;
      end else if (rx_take) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit; legal values 8 or 16.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits transmitted; legal values 1 or 2.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port n_reset, input, 1, reset: synchronous, active-low.
REQ-009 SHALL have port tx_data, input, DATA_BITS, word to transmit.
REQ-010 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-011 SHALL have port tx_ready, output, 1, transmitter can accept a word.
REQ-012 SHALL have port tx_pin, output, 1, serial output, idle high.
REQ-013 SHALL have port rx_pin, input, 1, asynchronous serial input.
REQ-014 SHALL have port rx_data, output, DATA_BITS, last received word.
REQ-015 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-016 SHALL have port rx_ready, input, 1, consumer takes rx_data.
REQ-017 SHALL have port rx_parity_err, output, 1, parity mismatch on the word in rx_data.
REQ-018 SHALL have port rx_frame_err, output, 1, first stop bit sampled low on the word in rx_data.
REQ-019 SHALL have port rx_overrun, output, 1, a frame was dropped because rx_valid was still set.

Function
REQ-020 SHALL derive DIV = CLK_HZ/(BAUD*OVERSAMPLE) with integer truncation; a free-running counter SHALL assert a one-cycle tick every DIV cycles, shared by TX and RX.
REQ-021 TX states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-022 tx_ready SHALL be 1 only in IDLE; a word SHALL be accepted on the cycle tx_valid&&tx_ready, and tx_ready SHALL be 0 from the next cycle.
REQ-023 tx_pin SHALL go low on the cycle after acceptance; START, each DATA bit, PARITY, and each stop bit SHALL each last OVERSAMPLE ticks; data SHALL be sent LSB first.
REQ-024 Parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-025 STOP SHALL drive 1 for STOP_BITS bit times, then return to IDLE with tx_ready=1 on the following cycle.
REQ-026 tx_data SHALL be captured at acceptance, so later changes to tx_data SHALL NOT affect the frame in flight.
REQ-027 rx_pin SHALL pass a 2-flop synchroniser, reset to 1s, before any use.
REQ-028 RX states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-029 In RX IDLE, a low synchronised sample on a tick SHALL enter START.
REQ-030 Each bit value SHALL be the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-031 If the start-bit majority is 1 (glitch), the receiver SHALL return to IDLE without any output change.
REQ-032 The receiver SHALL sample one stop bit only, regardless of STOP_BITS, and SHALL return to IDLE right after its majority sample, so that back-to-back frames are received.
REQ-033 On stop completion with rx_valid=0: rx_data, rx_parity_err and rx_frame_err SHALL update and rx_valid SHALL set, all in the same cycle.
REQ-034 On stop completion with rx_valid=1: the frame SHALL be discarded, rx_data and both error flags SHALL be unchanged, and rx_overrun SHALL set.
REQ-035 On rx_valid&&rx_ready, rx_valid and rx_overrun SHALL clear next cycle; if this coincides with a stop completion, the new frame SHALL be loaded, rx_valid SHALL stay 1, and no overrun SHALL be flagged.
REQ-036 rx_parity_err SHALL be 0 when PARITY=0.

Reset
REQ-037 While n_reset=0 at a clk edge, both FSMs SHALL go to IDLE and the tick counter SHALL clear, with outputs tx_pin=1, tx_ready=1, rx_valid=0, rx_data=0 and all error flags 0.
REQ-038 Reset mid-frame SHALL abort the frame with tx_pin high on the next cycle; no partial RX word SHALL be delivered.

Verification (CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 -> tick every cycle, bit = 16 cycles)
REQ-039 Bench SHALL send tx_data=0x55 with 8N1 -> tx_pin low 16 cycles then 1,0,1,0,1,0,1,0 at 16 cycles each, high 16, tx_ready back at cycle 161 after acceptance.
REQ-040 Bench SHALL loop tx_pin to rx_pin with PARITY=1 and send 0xA7 -> rx_valid=1, rx_data=0xA7, rx_parity_err=0.
REQ-041 Bench SHALL drive a frame 0x3C with parity bit inverted (PARITY=2), then one with stop bit 0 -> rx_parity_err=1, then rx_frame_err=1.
REQ-042 Bench SHALL hold rx_ready=0 over two frames 0x11 and 0x22 -> rx_data=0x11, rx_overrun=1; after handshake rx_valid=0 and rx_overrun=0.
REQ-043 Bench SHALL drive a 4-cycle low pulse on idle rx_pin -> no rx_valid, receiver back in IDLE.
REQ-044 Bench SHALL assert n_reset=0 during TX data bit 3 -> tx_pin=1 and tx_ready=1 on the next cycle, and a new word is accepted normally.
